// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 layer controller: FSM encoding and
// geometry helpers that derive buffer sizes from the layer parameters.
package conv1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int TIMEOUT_DEF = 20000;

  // Pooled outputs per channel: valid-conv edge divided by the pool window, squared.
  function automatic int o_cnt_f(input int i_size, input int k_size, input int p_size);
    int edge_len;
    edge_len = (i_size - k_size + 1) / p_size;
    return edge_len * edge_len;
  endfunction

  function automatic int ifmap_depth_f(input int i_size);
    return i_size * i_size;
  endfunction

endpackage

// File: rtl/conv1_layer_ctrl_if.sv
// Pixel stream, layer side-band, ofmap write bus and status for the conv1 controller.
// Pixel stream: a pixel transfers on a rising clk edge where i_pix_valid && o_pix_ready.
interface conv1_layer_ctrl_if #(
  parameter int I_BW   = 8,
  parameter int O_BW   = 16,
  parameter int ADDR_W = 10
);
  logic              i_start;
  logic [I_BW-1:0]   i_pix;
  logic              i_pix_valid;
  logic              o_pix_ready;
  logic [I_BW-1:0]   o_fmap;
  logic              o_mem_we;
  logic              o_ce;
  logic [O_BW-1:0]   i_conv_data;
  logic              i_conv_en;
  logic              i_ch_end;
  logic              i_allch_end;
  logic              o_ofmap_we;
  logic [ADDR_W-1:0] o_ofmap_addr;
  logic [O_BW-1:0]   o_ofmap_data;
  logic [1:0]        o_ch_idx;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport slave (
    input  i_start, i_pix, i_pix_valid, i_conv_data, i_conv_en, i_ch_end, i_allch_end,
    output o_pix_ready, o_fmap, o_mem_we, o_ce, o_ofmap_we, o_ofmap_addr, o_ofmap_data,
           o_ch_idx, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_pix, i_pix_valid, i_conv_data, i_conv_en, i_ch_end, i_allch_end,
    input  o_pix_ready, o_fmap, o_mem_we, o_ce, o_ofmap_we, o_ofmap_addr, o_ofmap_data,
           o_ch_idx, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv1_ofmap_addr_gen.sv
// Ofmap write address generator: per-channel output counter, channel counter,
// base multiply-add and overflow/short-channel detection.
module conv1_ofmap_addr_gen #(
  parameter int O_CNT  = 144,
  parameter int CO     = 4,
  parameter int ADDR_W = 10,
  parameter int O_BW   = 16,
  parameter int CH_W   = $clog2(CO + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              conv_en_i,
  input  logic [O_BW-1:0]   conv_data_i,
  input  logic              ch_end_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [O_BW-1:0]   data_o,
  output logic [CH_W-1:0]   ch_cnt_o,
  output logic              ch_last_o,
  output logic              err_o
);
  localparam int OC_W = $clog2(O_CNT + 1);

  logic [OC_W-1:0]   out_cnt_q, out_cnt_d, out_eff;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic              full, accept, we_q;
  logic [ADDR_W-1:0] addr_q, base;
  logic [O_BW-1:0]   data_q;

  assign full      = (out_cnt_q == OC_W'(O_CNT));
  assign accept    = en_i && conv_en_i && !full;
  // Count as seen by a same-cycle channel end, so a coincident last write is included.
  assign out_eff   = out_cnt_q + OC_W'(accept);
  assign base      = ADDR_W'(ch_cnt_q) * ADDR_W'(O_CNT) + ADDR_W'(out_cnt_q);
  assign ch_last_o = en_i && ch_end_i && (ch_cnt_q == CH_W'(CO - 1));
  assign err_o     = (en_i && conv_en_i && full) ||
                     (en_i && ch_end_i && (out_eff != OC_W'(O_CNT)));

  always_comb begin
    out_cnt_d = out_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    if (clr_i) begin
      out_cnt_d = '0;
      ch_cnt_d  = '0;
    end else if (en_i) begin
      if (ch_end_i) begin
        out_cnt_d = '0;
        if (ch_cnt_q != CH_W'(CO)) ch_cnt_d = ch_cnt_q + CH_W'(1);
      end else if (accept) begin
        out_cnt_d = out_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      ch_cnt_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      we_q      <= accept && !clr_i;
      if (accept) begin
        addr_q <= base;
        data_q <= conv_data_i;
      end
    end
  end

  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign data_o   = data_q;
  assign ch_cnt_o = ch_cnt_q;
endmodule

// File: rtl/conv1_layer_ctrl.sv
// Conv1 layer sequencer: loads one input fmap, runs all output channels,
// writes pooled results to the ofmap buffer and reports busy/done/error.
module conv1_layer_ctrl
  import conv1_pkg::*;
#(
  parameter int I_SIZE       = 28,
  parameter int K_SIZE       = 5,
  parameter int P_SIZE       = 2,
  parameter int CO           = 4,
  parameter int I_BW         = 8,
  parameter int O_BW         = 16,
  parameter int IFMAP_DEPTH  = ifmap_depth_f(I_SIZE),
  parameter int OFMAP_ADDR_W = 10,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               global_rst_n,
  input  logic               user_reset,
  conv1_layer_ctrl_if.slave  bus,
  output state_e             o_dbg_state
);
  localparam int O_CNT = o_cnt_f(I_SIZE, K_SIZE, P_SIZE);
  localparam int PIX_W = $clog2(IFMAP_DEPTH);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  localparam int CH_W  = $clog2(CO + 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             err_q, err_d, cnt_clr;
  logic             in_run, timeout_hit, allch_early;
  logic [CH_W-1:0]  ch_cnt;
  logic             ch_last, gen_err;

  assign in_run      = (state_q == ST_RUN);
  assign timeout_hit = (cyc_cnt_q == CYC_W'(TIMEOUT - 1));
  assign allch_early = bus.i_allch_end && (ch_cnt < CH_W'(CO)) && !ch_last;

  conv1_ofmap_addr_gen #(
    .O_CNT (O_CNT),
    .CO    (CO),
    .ADDR_W(OFMAP_ADDR_W),
    .O_BW  (O_BW),
    .CH_W  (CH_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (global_rst_n),
    .clr_i      (cnt_clr),
    .en_i       (in_run),
    .conv_en_i  (bus.i_conv_en),
    .conv_data_i(bus.i_conv_data),
    .ch_end_i   (bus.i_ch_end),
    .we_o       (bus.o_ofmap_we),
    .addr_o     (bus.o_ofmap_addr),
    .data_o     (bus.o_ofmap_data),
    .ch_cnt_o   (ch_cnt),
    .ch_last_o  (ch_last),
    .err_o      (gen_err)
  );

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d   = ST_LOAD;
          pix_cnt_d = '0;
          cyc_cnt_d = '0;
          err_d     = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.i_pix_valid) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(IFMAP_DEPTH - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        if (gen_err || allch_early || timeout_hit) err_d = 1'b1;
        if (bus.i_allch_end || ch_last || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (allch_early) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Soft reset aborts any frame silently: no done pulse, error cleared.
    if (user_reset) begin
      state_d   = ST_IDLE;
      pix_cnt_d = '0;
      cyc_cnt_d = '0;
      err_d     = 1'b0;
      cnt_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      cyc_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_pix_ready = (state_q == ST_LOAD);
  assign bus.o_mem_we    = (state_q == ST_LOAD) || in_run;
  assign bus.o_ce        = ((state_q == ST_LOAD) && bus.i_pix_valid) || in_run;
  assign bus.o_fmap      = (state_q == ST_LOAD) ? bus.i_pix : {I_BW{1'b0}};
  assign bus.o_busy      = (state_q == ST_LOAD) || in_run;
  assign bus.o_done      = (state_q == ST_DONE);
  assign bus.o_err       = err_q;
  assign bus.o_ch_idx    = (ch_cnt >= CH_W'(CO - 1)) ? 2'(CO - 1) : ch_cnt[1:0];
  assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_conv1_layer_ctrl.sv
// Randomized bench for conv1_layer_ctrl: a stub layer drives conv results,
// expected ofmap writes are queued at issue time and checked by a monitor.
module tb_conv1_layer_ctrl;
  import conv1_pkg::*;

  localparam int I_SIZE  = 28;
  localparam int K_SIZE  = 5;
  localparam int P_SIZE  = 2;
  localparam int CO      = 4;
  localparam int I_BW    = 8;
  localparam int O_BW    = 16;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = I_SIZE * I_SIZE;
  localparam int O_CNT   = ((I_SIZE - K_SIZE + 1) / P_SIZE) * ((I_SIZE - K_SIZE + 1) / P_SIZE);
  localparam int TIMEOUT = 20000;
  localparam int W       = ADDR_W + O_BW;
  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;

  logic   clk = 1'b0;
  logic   global_rst_n = 1'b0;
  logic   user_reset = 1'b0;
  state_e dbg_state;

  conv1_layer_ctrl_if #(.I_BW(I_BW), .O_BW(O_BW), .ADDR_W(ADDR_W)) bus ();

  conv1_layer_ctrl dut (
    .clk         (clk),
    .global_rst_n(global_rst_n),
    .user_reset  (user_reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int done_cnt = 0;
  int ce_cnt = 0;
  int run_cyc = 0;
  int wr_cnt = 0;
  int ch_plan[4];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    if (bus.o_done) done_cnt++;
    if (int'(dbg_state) == S_LOAD && bus.o_ce) ce_cnt++;
    if (int'(dbg_state) == S_RUN) run_cyc++;
    if (bus.o_ofmap_we) begin
      wr_cnt++;
      checks++;
      got_w = {bus.o_ofmap_addr, bus.o_ofmap_data};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ofmap_write: got addr=%0d data=%h, expected no write", bus.o_ofmap_addr, bus.o_ofmap_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w != exp_w) begin
          errors++;
          $display("FAIL ofmap_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   got_w[W-1:O_BW], got_w[O_BW-1:0], exp_w[W-1:O_BW], exp_w[O_BW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    @(negedge clk);
    check("start_state", int'(dbg_state), S_LOAD);
    check("start_err_clear", int'(bus.o_err), 0);
    check("start_busy", int'(bus.o_busy), 1);
  endtask

  task automatic load_pixels(input bit stall, input int limit);
    int sent = 0;
    int guard = 0;
    int state_bad = 0;
    int fwd_bad = 0;
    bit v;
    while (sent < limit && guard < 10 * DEPTH) begin
      tick();
      v = stall ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.i_pix_valid = v;
      bus.i_pix = I_BW'($urandom);
      @(negedge clk);
      if (int'(dbg_state) != S_LOAD) state_bad++;
      if (bus.o_fmap != bus.i_pix || bus.o_ce != v || bus.o_mem_we != 1'b1) fwd_bad++;
      if (v && bus.o_pix_ready) sent++;
      guard++;
    end
    tick();
    bus.i_pix_valid = 1'b0;
    check("load_state_held", state_bad, 0);
    check("fmap_passthru", fwd_bad, 0);
    check("load_handshakes", sent, limit);
  endtask

  task automatic run_layer(input int nch, input bit coincide, input bit allch);
    bit err_m = 1'b0;
    for (int ch = 0; ch < nch; ch++) begin
      for (int k = 0; k < ch_plan[ch]; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
          bus.i_conv_en = 1'b0;
          bus.i_ch_end = 1'b0;
        end
        tick();
        bus.i_conv_en = 1'b1;
        bus.i_conv_data = O_BW'($urandom);
        bus.i_ch_end = coincide && (k == ch_plan[ch] - 1);
        if (k < O_CNT) exp_q.push_back({ADDR_W'(ch * O_CNT + k), bus.i_conv_data});
      end
      if (!coincide) begin
        tick();
        bus.i_conv_en = 1'b0;
        bus.i_ch_end = 1'b1;
      end
      tick();
      bus.i_conv_en = 1'b0;
      bus.i_ch_end = 1'b0;
      if (ch_plan[ch] != O_CNT) err_m = 1'b1;
      @(negedge clk);
      check($sformatf("ch_idx_after_end%0d", ch), int'(bus.o_ch_idx), (ch + 1 > CO - 1) ? CO - 1 : ch + 1);
      check($sformatf("err_after_end%0d", ch), int'(bus.o_err), int'(err_m));
    end
    if (allch) begin
      tick();
      bus.i_allch_end = 1'b1;
      tick();
      bus.i_allch_end = 1'b0;
    end
  endtask

  task automatic wait_done(input int done0, input int bound);
    int n = 0;
    while (done_cnt == done0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - done0, 1);
    check("idle_after_done", int'(dbg_state), S_IDLE);
    check("busy_after_done", int'(bus.o_busy), 0);
  endtask

  task automatic do_frame(input bit stall, input int nch, input bit coincide, input bit allch);
    int d0, w0, c0, r0, nwr;
    bit err_exp;
    d0 = done_cnt;
    w0 = wr_cnt;
    c0 = ce_cnt;
    r0 = run_cyc;
    do_start();
    load_pixels(stall, DEPTH);
    @(negedge clk);
    check("run_entered", int'(dbg_state), S_RUN);
    check("ready_low_in_run", int'(bus.o_pix_ready), 0);
    check("load_ce_pulses", ce_cnt - c0, DEPTH);
    run_layer(nch, coincide, allch);
    err_exp = (nch < CO);
    nwr = 0;
    for (int ch = 0; ch < nch; ch++) begin
      if (ch_plan[ch] != O_CNT) err_exp = 1'b1;
      nwr += (ch_plan[ch] < O_CNT) ? ch_plan[ch] : O_CNT;
    end
    wait_done(d0, TIMEOUT + 1000);
    check("ofmap_write_count", wr_cnt - w0, nwr);
    check("exp_q_drained", exp_q.size(), 0);
    check("err_final", int'(bus.o_err), int'(err_exp));
    if (nch < CO && !allch) check("timeout_run_cycles", run_cyc - r0, TIMEOUT);
  endtask

  initial begin
    int d0;
    bus.i_start = 1'b0;
    bus.i_pix = '0;
    bus.i_pix_valid = 1'b0;
    bus.i_conv_data = '0;
    bus.i_conv_en = 1'b0;
    bus.i_ch_end = 1'b0;
    bus.i_allch_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 global_rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", int'(dbg_state), S_IDLE);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_err", int'(bus.o_err), 0);
    check("rst_ready", int'(bus.o_pix_ready), 0);
    check("rst_ce_we", int'({bus.o_ce, bus.o_mem_we, bus.o_ofmap_we}), 0);
    check("rst_fmap", int'(bus.o_fmap), 0);
    check("rst_ch_idx", int'(bus.o_ch_idx), 0);

    ch_plan = '{O_CNT, O_CNT, O_CNT, O_CNT};
    do_frame(1'b0, CO, 1'b0, 1'b1);
    do_frame(1'b1, CO, 1'b1, 1'b1);
    ch_plan = '{100, O_CNT, O_CNT, O_CNT};
    do_frame(1'b0, CO, 1'b0, 1'b1);
    ch_plan = '{O_CNT, O_CNT, O_CNT, O_CNT};
    do_frame(1'b0, 2, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < CO; i++)
        ch_plan[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(O_CNT - 4, O_CNT + 4)) : O_CNT;
      do_frame(bit'($urandom_range(0, 1)), CO, bit'($urandom_range(0, 1)), 1'b1);
    end
    ch_plan = '{O_CNT, O_CNT, O_CNT, O_CNT};
    do_frame(1'b0, 1, 1'b0, 1'b0);

    // Soft reset part way through the pixel load
    d0 = done_cnt;
    do_start();
    load_pixels(1'b0, 400);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    @(negedge clk);
    check("ureset_busy", int'(bus.o_busy), 0);
    check("ureset_state", int'(dbg_state), S_IDLE);
    check("ureset_err", int'(bus.o_err), 0);
    repeat (5) @(negedge clk);
    check("ureset_no_done", done_cnt - d0, 0);

    // Hard reset in RUN, with a stray start that must be ignored first
    d0 = done_cnt;
    do_start();
    load_pixels(1'b0, DEPTH);
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    @(negedge clk);
    check("start_ignored_in_run", int'(dbg_state), S_RUN);
    repeat (20) tick();
    global_rst_n = 1'b0;
    #1;
    check("grst_busy_async", int'(bus.o_busy), 0);
    check("grst_state_async", int'(dbg_state), S_IDLE);
    tick();
    global_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("grst_no_done", done_cnt - d0, 0);
    do_frame(1'b0, CO, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
